// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam logic [NUM_LANES-1:0] WSTRB_ALL = {NUM_LANES{1'b1}};

    // Which requester owns the read data returning this cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } rd_own_e;

    function automatic logic is_read(input logic gnt, input logic we);
        return gnt & ~we;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, external and RAM-side signals around the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    import dmem_pkg::*;

    logic                 core_req;
    logic                 core_we;
    logic [ADDR_W-1:0]    core_addr;
    logic [DATA_W-1:0]    core_wdata;
    logic [NUM_LANES-1:0] core_wstrb;
    logic                 core_gnt;
    logic                 core_rvalid;
    logic [DATA_W-1:0]    core_rdata;
    logic                 core_stall;

    logic                 ext_req;
    logic                 ext_we;
    logic [ADDR_W-1:0]    ext_addr;
    logic [DATA_W-1:0]    ext_wdata;
    logic                 ext_gnt;
    logic                 ext_rvalid;
    logic [DATA_W-1:0]    ext_rdata;

    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [NUM_LANES-1:0] mem_wstrb;
    logic [DATA_W-1:0]    mem_rdata;

    // Requesters and RAM side
    modport master (
        output core_req, core_we, core_addr, core_wdata, core_wstrb,
        input  core_gnt, core_rvalid, core_rdata, core_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_wstrb,
        output core_gnt, core_rvalid, core_rdata, core_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_arb_prio.sv
// Per-cycle grant decision: ext wins over core unless the starve count forces a core grant.
// Starvation override is compiled in only with `DMEM_ARB_FAIRNESS_EN.
module dmem_arb_prio
`ifdef DMEM_ARB_FAIRNESS_EN
#(
    parameter  int unsigned STARVE_LIMIT = 4,
    localparam int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
)
`endif
(
    input  logic             rst,
    input  logic             core_req,
    input  logic             ext_req,
`ifdef DMEM_ARB_FAIRNESS_EN
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             core_gnt_c,
    output logic             ext_gnt_c
);

    logic core_force_c;

    always_comb begin
        core_force_c = 1'b0;
`ifdef DMEM_ARB_FAIRNESS_EN
        core_force_c = (starve_cnt >= CNT_W'(STARVE_LIMIT));
`endif
    end

    // No grants while reset is held; requests are re-arbitrated afterwards
    always_comb begin
        core_gnt_c = 1'b0;
        ext_gnt_c  = 1'b0;
        if (!rst) begin
            if (ext_req && !(core_req && core_force_c)) begin
                ext_gnt_c = 1'b1;
            end else if (core_req) begin
                core_gnt_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core LSU and an external loader/debug port.
// Define DMEM_ARB_FAIRNESS_EN to bound how long ext traffic can starve a waiting core.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef DMEM_ARB_FAIRNESS_EN
    , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    logic                 core_gnt_c;
    logic                 ext_gnt_c;
    rd_own_e              rd_own_q;
    rd_own_e              rd_own_d;

    logic                 mem_en_c;
    logic                 mem_we_c;
    logic [ADDR_W-1:0]    mem_addr_c;
    logic [DATA_W-1:0]    mem_wdata_c;
    logic [NUM_LANES-1:0] mem_wstrb_c;
    logic                 core_rvalid_c;
    logic                 ext_rvalid_c;
    logic [DATA_W-1:0]    core_rdata_c;
    logic [DATA_W-1:0]    ext_rdata_c;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;

    // Counts ext grants taken while the core sits waiting
    always_ff @(posedge clk) begin
        if (rst || core_gnt_c || !bus.core_req) begin
            starve_cnt_q <= '0;
        end else if (ext_gnt_c && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end

    dmem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .rst        (rst),
        .core_req   (bus.core_req),
        .ext_req    (bus.ext_req),
        .starve_cnt (starve_cnt_q),
        .core_gnt_c (core_gnt_c),
        .ext_gnt_c  (ext_gnt_c)
    );
`else
    dmem_arb_prio u_prio (
        .rst        (rst),
        .core_req   (bus.core_req),
        .ext_req    (bus.ext_req),
        .core_gnt_c (core_gnt_c),
        .ext_gnt_c  (ext_gnt_c)
    );
`endif

    // Read-owner state register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_own_q <= OWN_NONE;
        end else begin
            rd_own_q <= rd_own_d;
        end
    end

    // Next owner follows this cycle's read grant, so back-to-back reads pipeline
    always_comb begin
        rd_own_d = OWN_NONE;
        if (is_read(core_gnt_c, bus.core_we)) begin
            rd_own_d = OWN_CORE;
        end else if (is_read(ext_gnt_c, bus.ext_we)) begin
            rd_own_d = OWN_EXT;
        end
    end

    // Return-data steering; reset cancels a read still in flight
    always_comb begin
        core_rvalid_c = 1'b0;
        ext_rvalid_c  = 1'b0;
        core_rdata_c  = '0;
        ext_rdata_c   = '0;
        if (!rst) begin
            case (rd_own_q)
                OWN_CORE: begin
                    core_rvalid_c = 1'b1;
                    core_rdata_c  = bus.mem_rdata;
                end
                OWN_EXT: begin
                    ext_rvalid_c = 1'b1;
                    ext_rdata_c  = bus.mem_rdata;
                end
                default: begin
                    core_rvalid_c = 1'b0;
                    ext_rvalid_c  = 1'b0;
                end
            endcase
        end
    end

    // RAM port mux; ext accesses are always full-word
    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_wstrb_c = '0;
        if (core_gnt_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.core_we;
            mem_addr_c  = bus.core_addr;
            mem_wdata_c = bus.core_wdata;
            mem_wstrb_c = bus.core_wstrb;
        end else if (ext_gnt_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.ext_we;
            mem_addr_c  = bus.ext_addr;
            mem_wdata_c = bus.ext_wdata;
            mem_wstrb_c = WSTRB_ALL;
        end
    end

    assign bus.core_gnt    = core_gnt_c;
    assign bus.ext_gnt     = ext_gnt_c;
    assign bus.core_stall  = bus.core_req & ~core_gnt_c;
    assign bus.core_rvalid = core_rvalid_c;
    assign bus.core_rdata  = core_rdata_c;
    assign bus.ext_rvalid  = ext_rvalid_c;
    assign bus.ext_rdata   = ext_rdata_c;
    assign bus.mem_en      = mem_en_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;
    assign bus.mem_wstrb   = mem_wstrb_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a request/response reference model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding reads per requester and ext wins in a row over a waiting core
    bit m_core_pend = 1'b0;
    bit m_ext_pend  = 1'b0;
    int m_streak    = 0;
    bit m_cg        = 1'b0;

    logic        last_core_gnt, last_ext_gnt, last_stall, last_mem_en, last_mem_we;
    logic [3:0]  last_mem_wstrb;
    logic        last_core_rvalid, last_ext_rvalid;
    logic [31:0] last_core_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one clock cycle of combinational outputs, advance the model, move to next negedge
    task automatic cycle(input string name);
        bit          cg, eg;
        logic [31:0] e_addr, e_wdata, e_crd, e_erd;
        logic [3:0]  e_strb;
        bit          e_we;
        #1;
        cg = !rst && bus.core_req && (!bus.ext_req || (FAIR && m_streak >= LIMIT));
        eg = !rst && bus.ext_req && !cg;
        e_we    = cg ? bus.core_we    : (eg ? bus.ext_we    : 1'b0);
        e_addr  = cg ? bus.core_addr  : (eg ? bus.ext_addr  : 32'h0);
        e_wdata = cg ? bus.core_wdata : (eg ? bus.ext_wdata : 32'h0);
        e_strb  = cg ? bus.core_wstrb : (eg ? 4'hF          : 4'h0);
        e_crd   = (!rst && m_core_pend) ? bus.mem_rdata : 32'h0;
        e_erd   = (!rst && m_ext_pend)  ? bus.mem_rdata : 32'h0;

        chk({name, ".core_gnt"},    64'(bus.core_gnt),    64'(cg));
        chk({name, ".ext_gnt"},     64'(bus.ext_gnt),     64'(eg));
        chk({name, ".core_stall"},  64'(bus.core_stall),  64'(bus.core_req && !cg));
        chk({name, ".mem_en"},      64'(bus.mem_en),      64'(cg || eg));
        chk({name, ".mem_we"},      64'(bus.mem_we),      64'(e_we));
        chk({name, ".mem_addr"},    64'(bus.mem_addr),    64'(e_addr));
        chk({name, ".mem_wdata"},   64'(bus.mem_wdata),   64'(e_wdata));
        chk({name, ".mem_wstrb"},   64'(bus.mem_wstrb),   64'(e_strb));
        chk({name, ".core_rvalid"}, 64'(bus.core_rvalid), 64'(!rst && m_core_pend));
        chk({name, ".ext_rvalid"},  64'(bus.ext_rvalid),  64'(!rst && m_ext_pend));
        chk({name, ".core_rdata"},  64'(bus.core_rdata),  64'(e_crd));
        chk({name, ".ext_rdata"},   64'(bus.ext_rdata),   64'(e_erd));

        last_core_gnt    = bus.core_gnt;
        last_ext_gnt     = bus.ext_gnt;
        last_stall       = bus.core_stall;
        last_mem_en      = bus.mem_en;
        last_mem_we      = bus.mem_we;
        last_mem_wstrb   = bus.mem_wstrb;
        last_core_rvalid = bus.core_rvalid;
        last_ext_rvalid  = bus.ext_rvalid;
        last_core_rdata  = bus.core_rdata;

        m_cg = cg;
        if (rst) begin
            m_core_pend = 1'b0;
            m_ext_pend  = 1'b0;
            m_streak    = 0;
        end else begin
            m_core_pend = cg && !bus.core_we;
            m_ext_pend  = eg && !bus.ext_we;
            if (!bus.core_req || cg) m_streak = 0;
            else if (eg)             m_streak = m_streak + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_core(input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb);
        bus.core_req   = req;
        bus.core_we    = we;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
        bus.core_wstrb = strb;
    endtask

    task automatic set_ext(input bit req, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.ext_req   = req;
        bus.ext_we    = we;
        bus.ext_addr  = addr;
        bus.ext_wdata = wdata;
    endtask

    initial begin
        int first_core;
        rst = 1'b1;
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        bus.mem_rdata = 32'h0;
        @(negedge clk);

        // Reset: everything quiet, stall still follows core_req
        cycle("reset");
        chk("reset_mem_en", 64'(last_mem_en), 64'(0));
        set_core(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        cycle("reset_req");
        chk("reset_stall", 64'(last_stall), 64'(1));
        rst = 1'b0;

        // Core-only load
        cycle("t1_gnt");
        chk("t1_core_gnt", 64'(last_core_gnt), 64'(1));
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.mem_rdata = 32'hDEADBEEF;
        cycle("t1_rv");
        chk("t1_rvalid", 64'(last_core_rvalid), 64'(1));
        chk("t1_rdata", 64'(last_core_rdata), 64'(32'hDEADBEEF));

        // Simultaneous requests: ext write wins, core follows
        set_core(1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        set_ext(1'b1, 1'b1, 32'h20, 32'h1234);
        bus.mem_rdata = 32'h0;
        cycle("t2_both");
        chk("t2_ext_gnt", 64'(last_ext_gnt), 64'(1));
        chk("t2_stall", 64'(last_stall), 64'(1));
        chk("t2_wstrb", 64'(last_mem_wstrb), 64'(4'hF));
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        cycle("t2_core");
        chk("t2_core_gnt", 64'(last_core_gnt), 64'(1));
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.mem_rdata = 32'h5555AAAA;
        cycle("t2_rv");

        // Alternating ext/core reads with no bubbles
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                set_ext(1'b1, 1'b0, 32'h0, 32'h0);
                set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end else begin
                set_ext(1'b0, 1'b0, 32'h0, 32'h0);
                set_core(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
            end
            bus.mem_rdata = $urandom;
            cycle("t3_alt");
            chk("t3_ext_rvalid", 64'(last_ext_rvalid), 64'(i % 2 == 1));
            chk("t3_core_rvalid", 64'(last_core_rvalid), 64'(i > 0 && i % 2 == 0));
        end
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        cycle("t3_tail");

        // Starvation: both held for 10 cycles
        first_core = 0;
        set_core(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        set_ext(1'b1, 1'b1, 32'h44, 32'h99);
        for (int i = 1; i <= 10; i++) begin
            cycle("t4_starve");
            if (last_core_gnt === 1'b1 && first_core == 0) begin
                first_core = i;
                set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
        end
        chk("t4_first_core_gnt", 64'(first_core), 64'(FAIR ? 5 : 0));
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        cycle("t4_tail");

        // Reset while a core read is outstanding
        set_core(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        cycle("t5_gnt");
        set_core(1'b1, 1'b0, 32'h34, 32'h0, 4'h0);
        rst = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        cycle("t5_rst");
        chk("t5_rvalid", 64'(last_core_rvalid), 64'(0));
        chk("t5_rdata", 64'(last_core_rdata), 64'(0));
        chk("t5_mem_en", 64'(last_mem_en), 64'(0));
        chk("t5_rd_own", 64'(dut.rd_own_q), 64'(OWN_NONE));
        rst = 1'b0;
        cycle("t5_rearb");
        chk("t5_core_gnt", 64'(last_core_gnt), 64'(1));
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle("t5_tail");

        // Partial core store
        set_core(1'b1, 1'b1, 32'h8, 32'h0000BEEF, 4'b0011);
        cycle("t6_store");
        chk("t6_mem_we", 64'(last_mem_we), 64'(1));
        chk("t6_wstrb", 64'(last_mem_wstrb), 64'(4'b0011));
        set_core(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.mem_rdata = 32'h12345678;
        cycle("t6_after");
        chk("t6_core_rvalid", 64'(last_core_rvalid), 64'(0));
        chk("t6_ext_rvalid", 64'(last_ext_rvalid), 64'(0));

        // Random traffic; a pending request keeps its fields until granted
        for (int n = 0; n < 400; n++) begin
            if (!bus.core_req || m_cg) begin
                set_core(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom));
            end
            if (!bus.ext_req || last_ext_gnt) begin
                set_ext(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                        $urandom & 32'hFFFF_FFFC, $urandom);
            end
            rst = ($urandom_range(0, 39) == 0);
            bus.mem_rdata = $urandom;
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
